btn_event_sequencer: RTL

//  Avalon-MM master that configures and services the 4-bit button PIO slave (edge-capture + IRQ).

---
 rtl/btn_evt_pkg.sv | 22 ++
 rtl/btn_evt_fifo.sv | 65 ++++++
 rtl/btn_event_sequencer.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/btn_evt_pkg.sv
// Shared state encoding and PIO register map for the button event sequencer.
// Imported by the sequencer top and its event FIFO.
package btn_evt_pkg;

  typedef enum logic [2:0] {
    INIT,
    DRAIN,
    IDLE,
    RD_ADDR,
    RD_SAMP,
    CLEAR,
    PUSH,
    HOLDOFF
  } state_e;

  localparam int          BTN_W    = 4;
  localparam logic [1:0]  PIO_DATA = 2'd0;
  localparam logic [1:0]  PIO_MASK = 2'd2;
  localparam logic [1:0]  PIO_EDGE = 2'd3;
  localparam logic [31:0] CLR_ALL  = 32'hF;

endpackage

// File: rtl/btn_evt_fifo.sv
// Synchronous event FIFO: combinational head (0 when empty), push while full is dropped
// unless a pop happens in the same cycle, pop while empty is ignored.
module btn_evt_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_dat_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign count_o = count_q;
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // Pointers are power-of-two wide, so wrap is the natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/btn_event_sequencer.sv
// Avalon-MM master servicing a 4-bit button PIO: programs the irq mask, reads and clears
// edge capture on irq, applies a debounce holdoff and queues edge bitmaps for the application.
module btn_event_sequencer
  import btn_evt_pkg::*;
#(
  parameter int HOLDOFF_CYCLES = 500000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [BTN_W-1:0] mask_cfg,
  input  logic             cfg_load,
  input  logic             pio_irq,
  output logic [1:0]       avm_address,
  output logic             avm_chipselect,
  output logic             avm_write_n,
  output logic [31:0]      avm_writedata,
  input  logic [31:0]      avm_readdata,
  output logic             evt_valid,
  output logic [BTN_W-1:0] evt_data,
  input  logic             evt_ready,
  output logic             evt_overflow,
  input  logic             ovf_clr,
  output logic             busy
);

  localparam int               CNT_W        = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam logic [CNT_W-1:0] HOLDOFF_LOAD = CNT_W'(HOLDOFF_CYCLES - 1);

  state_e                        state_q, state_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [BTN_W-1:0]              cap_q, cap_d;
  logic                          cfg_pend_q, cfg_pend_d;
  logic                          ovf_q, ovf_d;
  logic                          cs_q, cs_d;
  logic                          wr_n_q, wr_n_d;
  logic [1:0]                    addr_q, addr_d;
  logic [31:0]                   wdata_q, wdata_d;

  logic                          fifo_push;
  logic                          fifo_pop;
  logic                          fifo_full;
  logic                          fifo_empty;
  logic [BTN_W-1:0]              fifo_head;
  logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count;
  logic                          init_issued;
  logic                          drop;
  logic                          unused_sigs;

  // The bus registers are loaded from the next state, so each state's transaction is on the
  // bus during that state. Out of reset the bus is idle, so INIT waits one cycle for its write.
  assign init_issued = cs_q && !wr_n_q && (addr_q == PIO_MASK);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cap_d      = cap_q;
    cfg_pend_d = cfg_pend_q | cfg_load;
    fifo_push  = 1'b0;
    case (state_q)
      INIT:    if (init_issued) state_d = DRAIN;
      DRAIN:   state_d = IDLE;
      IDLE: begin
        if (cfg_pend_q || cfg_load) begin
          state_d    = INIT;
          cfg_pend_d = 1'b0;
        end else if (enable && pio_irq) begin
          state_d = RD_ADDR;
        end
      end
      RD_ADDR: state_d = RD_SAMP;
      RD_SAMP: begin
        cap_d   = avm_readdata[BTN_W-1:0];
        state_d = CLEAR;
      end
      CLEAR:   state_d = (cap_q != '0) ? PUSH : IDLE;
      PUSH: begin
        fifo_push = 1'b1;
        cnt_d     = HOLDOFF_LOAD;
        state_d   = HOLDOFF;
      end
      HOLDOFF: begin
        if (cnt_q == '0) state_d = DRAIN;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = INIT;
    endcase
  end

  always_comb begin
    cs_d    = 1'b0;
    wr_n_d  = 1'b1;
    addr_d  = PIO_DATA;
    wdata_d = '0;
    case (state_d)
      INIT: begin
        cs_d    = 1'b1;
        wr_n_d  = 1'b0;
        addr_d  = PIO_MASK;
        wdata_d = 32'(mask_cfg);
      end
      DRAIN, CLEAR: begin
        cs_d    = 1'b1;
        wr_n_d  = 1'b0;
        addr_d  = PIO_EDGE;
        wdata_d = CLR_ALL;
      end
      RD_ADDR, RD_SAMP: begin
        cs_d   = 1'b1;
        addr_d = PIO_EDGE;
      end
      default: cs_d = 1'b0;
    endcase
  end

  // A push into a full FIFO is only lost when the consumer is not popping in that same cycle.
  assign fifo_pop = !fifo_empty && evt_ready;
  assign drop     = fifo_push && fifo_full && !fifo_pop;
  assign ovf_d    = drop | (ovf_q & ~ovf_clr);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= INIT;
      cnt_q      <= '0;
      cap_q      <= '0;
      cfg_pend_q <= 1'b0;
      ovf_q      <= 1'b0;
      cs_q       <= 1'b0;
      wr_n_q     <= 1'b1;
      addr_q     <= PIO_DATA;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cap_q      <= cap_d;
      cfg_pend_q <= cfg_pend_d;
      ovf_q      <= ovf_d;
      cs_q       <= cs_d;
      wr_n_q     <= wr_n_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  btn_evt_fifo #(
    .WIDTH (BTN_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push_i     (fifo_push),
    .push_dat_i (cap_q),
    .pop_i      (fifo_pop),
    .head_o     (fifo_head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count)
  );

  assign unused_sigs    = ^{avm_readdata[31:BTN_W], fifo_count};

  assign avm_chipselect = cs_q;
  assign avm_write_n    = wr_n_q;
  assign avm_address    = addr_q;
  assign avm_writedata  = wdata_q;
  assign evt_valid      = !fifo_empty;
  assign evt_data       = fifo_head;
  assign evt_overflow   = ovf_q;
  assign busy           = (state_q != IDLE);

endmodule
